// File: rtl/matmul_fila_columna_ctrl.sv
// Row-major issue sequencer for the NxN complex matrix multiplier, with in-flight result address tracking.
// Optional MATMUL_CTRL_CYCLE_COUNT_EN adds a saturating busy-cycle counter on CycleCount.
module matmul_fila_columna_ctrl #(
  parameter int N       = 4,
  parameter int AddrW   = 2,
  parameter int Latency = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             Start,
  input  logic             Hold,
  output logic [AddrW-1:0] FilaSel,
  output logic [AddrW-1:0] ColSel,
  output logic             EnableReg,
  output logic             ResultValid,
  output logic [AddrW-1:0] ResultFila,
  output logic [AddrW-1:0] ResultCol,
  output logic             Busy,
  output logic             Done
`ifdef MATMUL_CTRL_CYCLE_COUNT_EN
  ,
  output logic [15:0]      CycleCount
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [AddrW-1:0] LAST = AddrW'(N - 1);

  state_t           state;
  logic [Latency-1:0] vld_q;
  logic [AddrW-1:0] fila_q [Latency];
  logic [AddrW-1:0] col_q  [Latency];
  logic             pending;
  logic             last_issue;

  assign EnableReg   = (state == ISSUE) && !Hold;
  assign last_issue  = EnableReg && (FilaSel == LAST) && (ColSel == LAST);
  assign ResultValid = vld_q[Latency-1];
  assign ResultFila  = fila_q[Latency-1];
  assign ResultCol   = col_q[Latency-1];
  assign Busy        = (state != IDLE);
  assign Done        = (state == DONE);

  // The final stage is the result being presented now; DONE may follow it directly.
  always_comb begin
    pending = 1'b0;
    for (int k = 0; k < Latency - 1; k++) pending = pending | vld_q[k];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= IDLE;
      FilaSel <= '0;
      ColSel  <= '0;
      vld_q   <= '0;
      for (int k = 0; k < Latency; k++) begin
        fila_q[k] <= '0;
        col_q[k]  <= '0;
      end
    end else begin
      vld_q[0]  <= EnableReg;
      fila_q[0] <= FilaSel;
      col_q[0]  <= ColSel;
      for (int k = 1; k < Latency; k++) begin
        vld_q[k]  <= vld_q[k-1];
        fila_q[k] <= fila_q[k-1];
        col_q[k]  <= col_q[k-1];
      end
      case (state)
        IDLE: begin
          if (Start) begin
            state   <= ISSUE;
            FilaSel <= '0;
            ColSel  <= '0;
          end
        end
        ISSUE: begin
          if (last_issue) begin
            state <= DRAIN;
          end else if (EnableReg) begin
            ColSel <= ColSel + AddrW'(1);
            if (ColSel == LAST) FilaSel <= FilaSel + AddrW'(1);
          end
        end
        DRAIN: begin
          if (!pending) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MATMUL_CTRL_CYCLE_COUNT_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      CycleCount <= '0;
    end else if (state == IDLE && Start) begin
      CycleCount <= '0;
    end else if (Busy && CycleCount != 16'hFFFF) begin
      CycleCount <= CycleCount + 16'd1;
    end
  end
`endif

endmodule
